// File: rtl/rom_pixel_serializer.sv
// ============================================================================
// Module   : rom_pixel_serializer
// Brief    : Serializes font-ROM glyph rows into RGB pixels, MSB first, and
//            delays hsync/vsync so that sync stays aligned with colour.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rom_pixel_serializer #(
    parameter int                 ROM_LAT   = 2,
    parameter int                 COLOR_W   = 12,
    parameter logic [COLOR_W-1:0] FG_COLOR  = 12'hFFF,
    parameter logic [COLOR_W-1:0] BG_COLOR  = 12'h00F,
    parameter logic               SYNC_IDLE = 1'b1
) (
    input  logic               reloj,
    input  logic               resetM,
    input  logic               pix_tick,
    input  logic               video_on,
    input  logic [2:0]         Qh_lo,
    input  logic               txt_en,
    input  logic               hsync_i,
    input  logic               vsync_i,
    input  logic [7:0]         ROM_DATA,
    output logic [COLOR_W-1:0] RGB,
    output logic               pix_bit,
    output logic               hsync_o,
    output logic               vsync_o
);

    // Stage layout: {video_on, txt_en, hsync, vsync, col[2:0]}
    localparam int         c_STAGE_W   = 7;
    localparam logic [6:0] c_STAGE_RST = {1'b0, 1'b0, SYNC_IDLE, SYNC_IDLE, 3'b000};

    logic [c_STAGE_W-1:0] r_stage [ROM_LAT];
    logic [7:0]           r_shreg;
    logic                 r_pix_bit;
    logic [COLOR_W-1:0]   r_rgb;
    logic                 r_hsync;
    logic                 r_vsync;

    logic [c_STAGE_W-1:0] w_head;
    logic [c_STAGE_W-1:0] w_d;
    logic                 w_d_video_on;
    logic                 w_d_txt_en;
    logic                 w_d_hsync;
    logic                 w_d_vsync;
    logic [2:0]           w_d_col;
    logic                 w_load;
    logic                 w_bit;

    assign w_head       = {video_on, txt_en, hsync_i, vsync_i, Qh_lo};
    assign w_d          = r_stage[ROM_LAT-1];
    assign w_d_video_on = w_d[6];
    assign w_d_txt_en   = w_d[5];
    assign w_d_hsync    = w_d[4];
    assign w_d_vsync    = w_d[3];
    assign w_d_col      = w_d[2:0];

    // The last delay stage is aligned with ROM_DATA for the same address.
    assign w_load = (w_d_col == 3'd0);
    assign w_bit  = w_load ? ROM_DATA[7] : r_shreg[7];

    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            for (int i = 0; i < ROM_LAT; i++) begin
                r_stage[i] <= c_STAGE_RST;
            end
        end else if (pix_tick) begin
            r_stage[0] <= w_head;
            for (int i = 1; i < ROM_LAT; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            r_shreg   <= 8'h00;
            r_pix_bit <= 1'b0;
            r_rgb     <= {COLOR_W{1'b0}};
            r_hsync   <= SYNC_IDLE;
            r_vsync   <= SYNC_IDLE;
        end else if (pix_tick) begin
            r_shreg   <= w_load ? {ROM_DATA[6:0], 1'b0} : {r_shreg[6:0], 1'b0};
            r_pix_bit <= w_bit;
            if (!w_d_video_on) begin
                r_rgb <= {COLOR_W{1'b0}};
            end else if (w_d_txt_en && w_bit) begin
                r_rgb <= FG_COLOR;
            end else begin
                r_rgb <= BG_COLOR;
            end
            r_hsync <= w_d_hsync;
            r_vsync <= w_d_vsync;
        end
    end

    assign RGB     = r_rgb;
    assign pix_bit = r_pix_bit;
    assign hsync_o = r_hsync;
    assign vsync_o = r_vsync;

endmodule

`default_nettype wire
